// File: rtl/ring_counter_cfg_pkg.sv
// -----------------------------------------------------------------------------
// ring_counter_pkg : mode/dir encodings and sequence helpers for ring_counter_cfg
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  // Helpers work on a fixed wide vector; callers zero-extend an N-bit state into it.
  localparam int MAX_N = 32;
  localparam int IDX_W = $clog2(MAX_N);

  typedef logic [MAX_N-1:0] wide_t;

  function automatic wide_t width_mask(input int n);
    wide_t m;
    m = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic wide_t seed(input logic mode, input int n);
    wide_t s;
    s = '0;
    if (mode == MODE_RING && n > 0) s[0] = 1'b1;
    return s;
  endfunction

  function automatic logic is_legal(input wide_t val, input logic mode, input int n);
    int ones;
    int edges;
    ones  = 0;
    edges = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && val[i]) ones++;
    end
    for (int i = 0; i < MAX_N - 1; i++) begin
      if (i < n - 1 && val[i] != val[i+1]) edges++;
    end
    if ((val & ~width_mask(n)) != '0) return 1'b0;
    if (mode == MODE_RING) return (ones == 1);
    return (edges <= 1);
  endfunction

  function automatic wide_t next_val(input wide_t val, input logic mode, input logic dir,
                                     input int n);
    wide_t                r;
    logic                 fb;
    logic [IDX_W-1:0]     top;
    top = IDX_W'(n - 1);
    r   = '0;
    if (dir == DIR_LEFT) begin
      fb = (mode == MODE_JOHNSON) ? ~val[top] : val[top];
      r  = {val[MAX_N-2:0], fb};
    end else begin
      fb     = (mode == MODE_JOHNSON) ? ~val[0] : val[0];
      r      = val >> 1;
      r[top] = fb;
    end
    return r & width_mask(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ring_counter_cfg_if.sv
// -----------------------------------------------------------------------------
// ring_counter_cfg_if : control and status bundle of the ring/Johnson sequencer
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface ring_counter_cfg_if #(
  parameter int N          = 4,
  parameter int PRESCALE_W = 8
);
  logic                  en;
  logic                  mode;
  logic                  dir;
  logic [PRESCALE_W-1:0] div;
  logic                  load;
  logic [N-1:0]          load_val;
  logic [N-1:0]          out;
  logic                  step;
  logic                  wrap;
  logic                  err;

  modport master (
    output en, mode, dir, div, load, load_val,
    input  out, step, wrap, err
  );

  modport slave (
    input  en, mode, dir, div, load, load_val,
    output out, step, wrap, err
  );
endinterface

`default_nettype wire

// File: rtl/ring_counter_cfg_prescaler.sv
// -----------------------------------------------------------------------------
// ring_counter_prescaler : enabled-cycle divider, ticks once every div+1 cycles
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module ring_counter_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  wire logic                  clk,
  input  wire logic                  en,
  input  wire logic [PRESCALE_W-1:0] div,
  input  wire logic                  clr,
  output logic                       tick
);

  logic [PRESCALE_W-1:0] pcnt_q;
  logic [PRESCALE_W-1:0] pcnt_d;

  // >= rather than == so that lowering div mid-count fires on the next enabled cycle
  assign tick = en && (pcnt_q >= div);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    pcnt_q <= pcnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/ring_counter_cfg.sv
// -----------------------------------------------------------------------------
// ring_counter_cfg : runtime ring/Johnson phase sequencer with load and self-repair
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module ring_counter_cfg
  import ring_counter_pkg::*;
#(
  parameter int N          = 4,
  parameter int PRESCALE_W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ring_counter_cfg_if.slave bus
);

  logic [N-1:0] out_q;
  logic [N-1:0] out_d;
  logic         mode_q;
  logic         mode_d;
  logic         step_q;
  logic         step_d;
  logic         wrap_q;
  logic         wrap_d;
  logic         err_q;
  logic         err_d;
  logic         tick;
  logic         clr;

  wide_t        cur_w;
  wide_t        load_w;
  wide_t        seed_cur_w;
  wide_t        seed_in_w;
  wide_t        nxt_w;
  logic         unused_wide_bits;

  assign cur_w      = wide_t'(out_q);
  assign load_w     = wide_t'(bus.load_val);
  assign seed_cur_w = seed(mode_q, N);
  assign seed_in_w  = seed(bus.mode, N);
  assign nxt_w      = next_val(cur_w, mode_q, bus.dir, N);

  // Upper bits of the wide helpers are zero by construction.
  assign unused_wide_bits = ^{seed_in_w, nxt_w};

  ring_counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .en   (bus.en),
    .div  (bus.div),
    .clr  (rst | clr),
    .tick (tick)
  );

  always_comb begin
    out_d  = out_q;
    mode_d = mode_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    clr    = 1'b0;
    if (bus.mode != mode_q) begin
      out_d  = seed_in_w[N-1:0];
      mode_d = bus.mode;
      clr    = 1'b1;
    end else if (bus.load) begin
      clr = 1'b1;
      if (is_legal(load_w, mode_q, N)) begin
        out_d = bus.load_val;
      end else begin
        out_d = seed_cur_w[N-1:0];
        err_d = 1'b1;
      end
    end else if (!is_legal(cur_w, mode_q, N)) begin
      out_d = seed_cur_w[N-1:0];
      clr   = 1'b1;
      err_d = 1'b1;
    end else if (tick) begin
      out_d  = nxt_w[N-1:0];
      step_d = 1'b1;
      wrap_d = (nxt_w == seed_cur_w);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= seed_in_w[N-1:0];
      mode_q <= bus.mode;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      mode_q <= mode_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

endmodule

`default_nettype wire
